// File: rtl/pci_wb_mem_slave.sv
// Purpose : Wishbone memory responder behind the PCI target bridge.
//           It holds a word-addressed RAM and answers single-word reads and writes.
// Latency : STB is first sampled high at edge N. ACK or VALID is registered at
//           edge N+1+WAIT_STATES and stays high for one cycle.
// Backpr. : There is no stall signal. The master holds STB until it sees a
//           response. Out-of-range requests get no response, so the bridge
//           watchdog times them out.
//
// Ports:
//   PHY_CLK33_I / PHY_RSTn_I     : clock, synchronous active-low reset
//   WB_ADD_I, WB_DATA_I          : byte address ([1:0] ignored) and write data
//   WB_STB_I, WB_WE_I            : request strobe and direction (1 = write)
//   WB_DATA_O                    : read data, holds the value of the last read
//   WB_ACK_O / WB_VALID_O        : write-done and read-valid pulses
//   ERR_O, ERR_CLR_I             : sticky out-of-range flag and its clear
//   WR_CNT_O / RD_CNT_O          : saturating counts of completed writes and reads
module pci_wb_mem_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RSTn_I,
  input  logic [31:0] WB_ADD_I,
  input  logic [31:0] WB_DATA_I,
  input  logic        WB_STB_I,
  input  logic        WB_WE_I,
  output logic [31:0] WB_DATA_O,
  output logic        WB_ACK_O,
  output logic        WB_VALID_O,
  output logic        ERR_O,
  input  logic        ERR_CLR_I,
  output logic [15:0] WR_CNT_O,
  output logic [15:0] RD_CNT_O
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_HOLD,
    ST_IGNORE
  } state_t;

  // A 4-bit counter covers the legal range of 0..10 wait states.
  localparam logic [3:0] WS = WAIT_STATES[3:0];

  logic [31:0]       mem [2**ADDR_W];
  state_t            state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdat_q;
  logic              in_range;
  logic              addr_lsb_unused;

  assign in_range        = (WB_ADD_I[31:ADDR_W+2] == '0);
  assign addr_lsb_unused = ^WB_ADD_I[1:0];

  // The request latches (we_q, idx_q, wdat_q) and the RAM are not reset.
  // A reset returns the FSM to IDLE, so stale latched values are never used.
  always_ff @(posedge PHY_CLK33_I) begin
    if (!PHY_RSTn_I) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      WB_DATA_O  <= '0;
      WB_ACK_O   <= 1'b0;
      WB_VALID_O <= 1'b0;
      ERR_O      <= 1'b0;
      WR_CNT_O   <= '0;
      RD_CNT_O   <= '0;
    end else begin
      // The pulses last one cycle by default. Only the WAIT->RESP transition raises them.
      WB_ACK_O   <= 1'b0;
      WB_VALID_O <= 1'b0;

      // A clear can be overridden by a set later in this block, so set wins.
      if (ERR_CLR_I) begin
        ERR_O <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (WB_STB_I) begin
            if (in_range) begin
              we_q     <= WB_WE_I;
              idx_q    <= WB_ADD_I[ADDR_W+1:2];
              wdat_q   <= WB_DATA_I;
              wait_cnt <= '0;
              state    <= ST_WAIT;
            end else begin
              ERR_O <= 1'b1;
              state <= ST_IGNORE;
            end
          end
        end

        ST_WAIT: begin
          if (!WB_STB_I) begin
            // The master abandoned the request. Nothing is written or answered.
            state <= ST_IDLE;
          end else if (wait_cnt == WS) begin
            if (we_q) begin
              mem[idx_q] <= wdat_q;
              WB_ACK_O   <= 1'b1;
            end else begin
              WB_DATA_O  <= mem[idx_q];
              WB_VALID_O <= 1'b1;
            end
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end

        ST_RESP: begin
          if (we_q) begin
            if (WR_CNT_O != 16'hFFFF) begin
              WR_CNT_O <= WR_CNT_O + 16'd1;
            end
          end else begin
            if (RD_CNT_O != 16'hFFFF) begin
              RD_CNT_O <= RD_CNT_O + 16'd1;
            end
          end
          state <= ST_HOLD;
        end

        // A STB that is still high here belongs to the request just answered.
        // Wait for STB to go low before accepting a new request.
        ST_HOLD: begin
          if (!WB_STB_I) begin
            state <= ST_IDLE;
          end
        end

        ST_IGNORE: begin
          if (!WB_STB_I) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
